// File: rtl/out_port_arbiter.sv
// Round-robin arbiter/sequencer for one switch output port: grants one of PORTS_NUM+1 requesters,
// forwards its flit and runs the ready/ack handshake. Optional HOLD watchdog: PGNOC_ARB_TIMEOUT_EN.
module out_port_arbiter #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned ADDR_SIZE = 4,
   parameter int unsigned PORTS_NUM = 4,
   parameter int unsigned TIMEOUT   = 64,
   localparam int unsigned BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1,
   localparam int unsigned REQ_NUM  = PORTS_NUM + 1
) (
   input  logic                        clk,
   input  logic                        a_rst_n,
   input  logic [REQ_NUM-1:0]          req_i,
   input  logic [BUS_SIZE*REQ_NUM-1:0] data_i,
   input  logic                        r_ready_i,
   output logic [REQ_NUM-1:0]          ack_o,
   output logic [REQ_NUM-1:0]          grant_o,
   output logic                        valid_o,
   output logic [BUS_SIZE-1:0]         data_o,
   output logic                        timeout_o
);

   localparam int unsigned PTR_W = $clog2(REQ_NUM);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [PTR_W-1:0]     ptr, ptr_n;
   logic [PTR_W-1:0]     gidx, gidx_n;
   logic [PTR_W-1:0]     sel_idx;
   logic                 sel_found;
   logic [REQ_NUM-1:0]   grant_n;
   logic [REQ_NUM-1:0]   ack_n;
   logic                 valid_n;
   logic [BUS_SIZE-1:0]  data_n;
   logic [BUS_SIZE-1:0]  slice [REQ_NUM];

`ifdef PGNOC_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic                 timeout_n;
`endif

   for (genvar i = 0; i < REQ_NUM; i++) begin : g_slice
      assign slice[i] = data_i[i*BUS_SIZE +: BUS_SIZE];
   end

   // First requester after the last served one, wrapping modulo REQ_NUM.
   always_comb begin
      int unsigned cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= REQ_NUM; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= REQ_NUM) cand = cand - REQ_NUM;
         if (!sel_found && req_i[PTR_W'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'(cand);
         end
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      gidx_n    = gidx;
      grant_n   = grant_o;
      ack_n     = '0;
      valid_n   = valid_o;
      data_n    = data_o;
`ifdef PGNOC_ARB_TIMEOUT_EN
      cnt_n     = cnt;
      timeout_n = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (sel_found) begin
               gidx_n  = sel_idx;
               grant_n = REQ_NUM'(1) << sel_idx;
               data_n  = slice[sel_idx];
               valid_n = 1'b1;
               state_n = HOLD;
`ifdef PGNOC_ARB_TIMEOUT_EN
               cnt_n   = '0;
`endif
            end
         end
         HOLD: begin
            if (r_ready_i) begin
               valid_n = 1'b0;
               ack_n   = grant_o;
               ptr_n   = gidx;
               state_n = RELEASE;
            end
`ifdef PGNOC_ARB_TIMEOUT_EN
            else begin
               cnt_n = cnt + CNT_W'(1);
               // Abandon the stalled flit; the requester goes to the back of the rotation.
               if (cnt_n == CNT_W'(TIMEOUT)) begin
                  valid_n   = 1'b0;
                  grant_n   = '0;
                  timeout_n = 1'b1;
                  ptr_n     = gidx;
                  state_n   = IDLE;
               end
            end
`endif
         end
         RELEASE: begin
            // Hold the grant until the served request drops so it is never re-granted stale.
            if (!req_i[gidx]) begin
               grant_n = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state   <= IDLE;
         ptr     <= PTR_W'(PORTS_NUM);
         gidx    <= '0;
         grant_o <= '0;
         ack_o   <= '0;
         valid_o <= 1'b0;
         data_o  <= '0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         gidx    <= gidx_n;
         grant_o <= grant_n;
         ack_o   <= ack_n;
         valid_o <= valid_n;
         data_o  <= data_n;
      end
   end

`ifdef PGNOC_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         cnt       <= '0;
         timeout_o <= 1'b0;
      end else begin
         cnt       <= cnt_n;
         timeout_o <= timeout_n;
      end
   end
`else
   // Watchdog absent; TIMEOUT is referenced only to keep the parameter tied in.
   assign timeout_o = 1'b0 & (TIMEOUT == 32'd0);
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: expected grants/flits go to a scoreboard when requests are
// driven and are checked when valid_o rises. Watchdog section follows PGNOC_ARB_TIMEOUT_EN.
module tb_out_port_arbiter;

   localparam int unsigned DATA_SIZE = 32;
   localparam int unsigned ADDR_SIZE = 4;
   localparam int unsigned PORTS_NUM = 4;
   localparam int unsigned TO        = 8;
   localparam int unsigned BUS       = DATA_SIZE + ADDR_SIZE + 1;
   localparam int unsigned N         = PORTS_NUM + 1;

   typedef struct {
      logic [N-1:0]   grant;
      logic [BUS-1:0] data;
   } sb_item_t;

   sb_item_t sb[$];

   logic             clk = 1'b0;
   logic             a_rst_n;
   logic [N-1:0]     req_i;
   logic [BUS*N-1:0] data_i;
   logic             r_ready_i;
   logic [N-1:0]     ack_o;
   logic [N-1:0]     grant_o;
   logic             valid_o;
   logic [BUS-1:0]   data_o;
   logic             timeout_o;

   logic [BUS-1:0]   slice_val [N];
   int               n_total = 0;
   int               n_pass  = 0;
   int               n_fail  = 0;

   out_port_arbiter #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE),
      .PORTS_NUM (PORTS_NUM),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .a_rst_n   (a_rst_n),
      .req_i     (req_i),
      .data_i    (data_i),
      .r_ready_i (r_ready_i),
      .ack_o     (ack_o),
      .grant_o   (grant_o),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic pack_data();
      data_i = {slice_val[4], slice_val[3], slice_val[2], slice_val[1], slice_val[0]};
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_grant"},   64'(grant_o),   64'(0));
      check({tag, "_ack"},     64'(ack_o),     64'(0));
      check({tag, "_valid"},   64'(valid_o),   64'(0));
      check({tag, "_data"},    64'(data_o),    64'(0));
      check({tag, "_timeout"}, 64'(timeout_o), 64'(0));
   endtask

   task automatic push_exp(input logic [2:0] port);
      sb_item_t it;
      it.grant = N'(1) << port;
      it.data  = slice_val[port];
      sb.push_back(it);
   endtask

   // Waits (bounded) for valid_o, then pops the oldest expected flit and compares.
   task automatic wait_grant(input string tag);
      sb_item_t it;
      int n;
      n = 0;
      while (valid_o !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      check({tag, "_valid"},   64'(valid_o),   64'(1));
      check({tag, "_latency"}, 64'(n),         64'(0));
      if (sb.size() > 0) begin
         it = sb.pop_front();
         check({tag, "_grant"}, 64'(grant_o), 64'(it.grant));
         check({tag, "_data"},  64'(data_o),  64'(it.data));
      end else begin
         check({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
      end
      check({tag, "_ack0"},    64'(ack_o),     64'(0));
      check({tag, "_timeout"}, 64'(timeout_o), 64'(0));
   endtask

   // One full flit: request, grant, optional stall with data churn, ack, release.
   task automatic transfer(input logic [N-1:0] raise, input logic [N-1:0] late,
                           input logic [2:0] exp_port, input int hold_wait, input string tag);
      logic [N-1:0]   g;
      logic [BUS-1:0] exp_d;
      g     = N'(1) << exp_port;
      exp_d = slice_val[exp_port];
      push_exp(exp_port);
      req_i = req_i | raise;
      tick();
      wait_grant(tag);
      for (int c = 0; c < hold_wait; c++) begin
         if (c == 0) begin
            slice_val[exp_port] = ~slice_val[exp_port];
            pack_data();
         end
         tick();
         check({tag, "_hold_valid"}, 64'(valid_o),   64'(1));
         check({tag, "_hold_data"},  64'(data_o),    64'(exp_d));
         check({tag, "_hold_ack"},   64'(ack_o),     64'(0));
         check({tag, "_hold_to"},    64'(timeout_o), 64'(0));
      end
      req_i     = req_i | late;
      r_ready_i = 1'b1;
      tick();
      r_ready_i = 1'b0;
      check({tag, "_ack"},       64'(ack_o),   64'(g));
      check({tag, "_ack_valid"}, 64'(valid_o), 64'(0));
      check({tag, "_ack_data"},  64'(data_o),  64'(exp_d));
      check({tag, "_ack_grant"}, 64'(grant_o), 64'(g));
      tick();
      check({tag, "_rel_ack"},   64'(ack_o),   64'(0));
      check({tag, "_rel_grant"}, 64'(grant_o), 64'(g));
      req_i = req_i & ~g;
      tick();
      check({tag, "_idle_grant"}, 64'(grant_o), 64'(0));
   endtask

   initial begin
      a_rst_n   = 1'b0;
      req_i     = '0;
      r_ready_i = 1'b0;
      for (int i = 0; i < int'(N); i++)
         slice_val[i] = {1'b1, 4'(i), 32'hC0DE_0000 | 32'(i)};
      slice_val[2] = 37'h1_2345_6789;
      pack_data();
      tick();
      tick();
      check_quiet("reset");
      @(negedge clk);
      a_rst_n = 1'b1;
      tick();
      check_quiet("post_reset");

      // Single flit on port 2, ready two cycles after valid, data churned meanwhile.
      transfer(5'b00100, 5'b00000, 3'd2, 2, "single");

      // Asynchronous reset in the middle of HOLD.
      push_exp(3'd3);
      req_i = 5'b01000;
      tick();
      wait_grant("rst_pre");
      #2;
      a_rst_n = 1'b0;
      #1;
      check_quiet("rst_mid");
      req_i = '0;
      @(negedge clk);
      a_rst_n = 1'b1;
      tick();
      check_quiet("rst_after");

      // Round robin with everyone requesting: 0,1,2,3,4,0.
      transfer(5'b11111, 5'b00000, 3'd0, 0, "rr0");
      transfer(5'b11111, 5'b00000, 3'd1, 0, "rr1");
      transfer(5'b11111, 5'b00000, 3'd2, 0, "rr2");
      transfer(5'b11111, 5'b00000, 3'd3, 0, "rr3");
      transfer(5'b11111, 5'b00000, 3'd4, 0, "rr4");
      transfer(5'b11111, 5'b00000, 3'd0, 0, "rr5");
      req_i = '0;
      tick();
      check("rr_drain_valid", 64'(valid_o), 64'(0));

      // Late requester 1 during port 3's HOLD: served next.
      transfer(5'b01000, 5'b00010, 3'd3, 1, "late_a");
      transfer(5'b00000, 5'b00000, 3'd1, 0, "late_a_next");

      // Late requesters 1 and 4 arriving together with r_ready: 4 precedes 1.
      transfer(5'b01000, 5'b10010, 3'd3, 0, "late_b");
      transfer(5'b00000, 5'b00000, 3'd4, 0, "late_b_4");
      transfer(5'b00000, 5'b00000, 3'd1, 0, "late_b_1");

`ifdef PGNOC_ARB_TIMEOUT_EN
      // Port 2 stalls until the watchdog fires; port 0 is served before port 2 retries.
      push_exp(3'd2);
      req_i = req_i | 5'b00101;
      tick();
      wait_grant("to_grant");
      for (int c = 0; c < int'(TO) - 1; c++) begin
         tick();
         check("to_wait_timeout", 64'(timeout_o), 64'(0));
         check("to_wait_valid",   64'(valid_o),   64'(1));
         check("to_wait_ack",     64'(ack_o),     64'(0));
      end
      tick();
      check("to_fire_timeout", 64'(timeout_o), 64'(1));
      check("to_fire_grant",   64'(grant_o),   64'(0));
      check("to_fire_valid",   64'(valid_o),   64'(0));
      check("to_fire_ack",     64'(ack_o),     64'(0));
      transfer(5'b00000, 5'b00000, 3'd0, 0, "to_next");
      transfer(5'b00000, 5'b00000, 3'd2, 0, "to_retry");
`else
      // Without the watchdog a long stall just waits; timeout_o stays low.
      transfer(5'b00101, 5'b00000, 3'd2, 20, "long_hold");
      transfer(5'b00000, 5'b00000, 3'd0, 0, "long_next");
`endif

      req_i = '0;
      tick();
      check("end_grant", 64'(grant_o), 64'(0));
      check("end_sb",    64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Round-robin arbiter and sequencer for one switch output port. Up to PORTS_NUM+1 input-side transceivers (four neighbour ports plus the local port) request the same output link. The arbiter grants exactly one of them, forwards that flit to the link, and completes the ready/ack handshake with both sides. One instance sits per output port inside the switch, between the transceivers' per-port `wr_ready`/data outputs and the neighbour's input queue.

## Interface
- DATA_SIZE, 32, flit payload width
- ADDR_SIZE, 4, destination address width
- PORTS_NUM, 4, neighbour ports; requesters = PORTS_NUM+1
- TIMEOUT, 64, HOLD watchdog limit in cycles (used only with the macro); counter width $clog2(TIMEOUT+1)
- BUS_SIZE (localparam), DATA_SIZE+ADDR_SIZE+1, flit bus width
- clk  input  1  clock, rising edge
- a_rst_n  input  1  asynchronous active-low reset
- req_i  input  PORTS_NUM+1  per-requester flit-valid (transceiver `wr_ready_out` bit for this port)
- data_i  input  BUS_SIZE*(PORTS_NUM+1)  concatenated flit buses; requester i at [i*BUS_SIZE +: BUS_SIZE]
- r_ready_i  input  1  downstream accepted the flit on data_o
- ack_o  output  PORTS_NUM+1  one-cycle accept pulse to the granted requester
- grant_o  output  PORTS_NUM+1  one-hot current grant, 0 when idle
- valid_o  output  1  flit on data_o is valid
- data_o  output  BUS_SIZE  forwarded flit
- timeout_o  output  1  one-cycle pulse on watchdog expiry

## Operation
- Reset (a_rst_n=0, takes effect immediately): state=IDLE, grant_o=0, ack_o=0, valid_o=0, data_o=0, timeout_o=0, ptr=PORTS_NUM, so requester 0 has first priority.
- States: IDLE(2'd0), HOLD(2'd1), RELEASE(2'd2); encoding 2'd3 → IDLE.
- IDLE: when req_i≠0, select the first set bit searching ptr+1, ptr+2, … modulo PORTS_NUM+1. Register grant_o=onehot(g), data_o=data_i slice g, valid_o=1, then go to HOLD. If req_i=0, stay in IDLE.
- HOLD: data_o and grant_o are frozen; later changes to data_i are ignored. A drop of req_i[g] is ignored. When r_ready_i=1: valid_o←0, ack_o[g]←1, ptr←g, go to RELEASE.
- RELEASE: ack_o←0 after one cycle. Wait until req_i[g]=0, then grant_o←0 and go to IDLE. The next grant therefore can never reuse a stale request.
- r_ready_i is ignored outside HOLD.
- Requests from non-granted ports are held pending. They are never lost or acked.
- Fairness: a continuously requesting port waits at most PORTS_NUM grants.

## Timing
- Grant latency: req_i sampled high at edge N in IDLE → grant_o/valid_o/data_o valid after edge N.
- Ack latency: r_ready_i high at edge M in HOLD → ack_o high and valid_o low for cycle M+1 only.
- Minimum flit period: 3 cycles (IDLE, HOLD with immediate r_ready_i, RELEASE with req already dropped).
- Simultaneous request and ack: a new request arriving in the same cycle as r_ready_i waits for the IDLE pass.
- Multiple requests in one IDLE cycle: exactly one grant, chosen by the round-robin order.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- PGNOC_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to HOLD and increments each HOLD cycle while r_ready_i=0.
  - When it reaches TIMEOUT: valid_o←0, grant_o←0, timeout_o pulses 1 cycle, ack_o stays 0, ptr←g, next state IDLE.
  - The abandoned requester re-arbitrates after the others.
- Undefined: no counter; HOLD waits indefinitely; timeout_o tied to 0.

## Test plan
- Reset: drive a_rst_n low mid-HOLD → all outputs are 0 within the same cycle; after release, a request from port 0 (alone) is granted first.
- Single flit: req_i=5'b00100, data_i slice 2=37'h1_2345_6789, r_ready_i high 2 cycles after valid_o → data_o=37'h1_2345_6789, ack_o=5'b00100 for exactly 1 cycle, valid_o low the same cycle; grant_o clears after req_i[2] drops.
- Round robin: req_i=5'b11111 held, requesters drop and re-raise after each ack → grant order 0,1,2,3,4,0.
- Contention with a late requester: port 3 granted; port 1 raises req in HOLD → port 1 not acked until port 3 completes; next grant is port 4 if requesting, else 1.
- Data freeze: change data_i slice g during HOLD → data_o unchanged until ack.
- With PGNOC_ARB_TIMEOUT_EN, TIMEOUT=8, r_ready_i held 0 → timeout_o pulses after 8 HOLD cycles, ack_o never set, next grant goes to the next requester.
